// File: rtl/video_timing_pkg.sv
// Shared video timing constants, fetch FSM states and colour-bar helpers
// for the 800x600 line fetch path.
package video_timing_pkg;

    localparam int H_VISIBLE      = 800;
    localparam int V_VISIBLE      = 600;
    localparam int V_LAST_VISIBLE = 599;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ABORT,
        DONE
    } fetch_state_t;

    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    // Eight 100-pixel bars; a compare chain stands in for h/100.
    function automatic rgb565_t bar_colour(input logic [9:0] h);
        if (h < 10'd100)      return BAR_WHITE;
        else if (h < 10'd200) return BAR_YELLOW;
        else if (h < 10'd300) return BAR_CYAN;
        else if (h < 10'd400) return BAR_GREEN;
        else if (h < 10'd500) return BAR_MAGENTA;
        else if (h < 10'd600) return BAR_RED;
        else if (h < 10'd700) return BAR_BLUE;
        else                  return BAR_BLACK;
    endfunction

    // row*800 built from shifts: 800 = 512 + 256 + 32.
    function automatic logic [19:0] row_offset(input logic [9:0] row);
        logic [19:0] r;
        r = {10'd0, row};
        return (r << 9) + (r << 8) + (r << 5);
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Ping-pong line store: two banks of one visible row each, one write port
// fed by the fetch engine and one registered read port feeding the video pipe.
module line_buffer_ram
    import video_timing_pkg::*;
#(
    parameter int WORDS  = H_VISIBLE,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [9:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [9:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:1][0:WORDS-1];

    // Write port: store fetched words into the back bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Read port: one-cycle registered read of the display bank.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/line_fetch_buffer.sv
// Line fetch buffer: prefetches the next visible row from framebuffer memory
// into a ping-pong line store and streams the current row out with a fixed
// two-cycle latency, delaying syncs by the same amount.
// Optional build macro: TEST_PATTERN_EN adds test_pattern_sel and a colour-bar
// source that replaces the line buffer output while selected.
module line_fetch_buffer
    import video_timing_pkg::*;
#(
    parameter logic [19:0] FB_BASE    = 20'h00000,
    parameter int          LINE_WORDS = 800,
    parameter int          DATA_W     = 16
) (
    input  logic              clk40,
    input  logic              reset,
    input  logic              line_starting,
    input  logic              video_active,
    input  logic [9:0]        h_pos,
    input  logic              next_frame_active,
    input  logic [9:0]        next_v_pos,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              mem_req,
    output logic [19:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] pixel_rgb,
    output logic              pixel_active,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              underrun,
    input  logic              underrun_clear
`ifdef TEST_PATTERN_EN
    ,
    input  logic              test_pattern_sel
`endif
);

    localparam logic [9:0] LAST_COL = 10'(LINE_WORDS - 1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [9:0]        col;
    logic [9:0]        pending_row;
    logic [9:0]        sel_row;
    logic              disp_bank;
    logic [1:0]        bank_valid;
    logic              ram_wr_en;
    logic              underrun_set;

    logic [9:0]        s1_h_pos;
    logic              s1_active;
    logic              s1_hsync;
    logic              s1_vsync;
    logic              s1_bank;
    logic              s1_valid;
    logic              s2_active;
    logic              s2_hsync;
    logic              s2_vsync;
    logic              s2_valid;
    logic [DATA_W-1:0] ram_q;
`ifdef TEST_PATTERN_EN
    logic              s1_tp_sel;
    logic              s2_tp_sel;
    rgb565_t           s2_bar;
`endif

    function automatic logic [19:0] fetch_base(input logic [9:0] row);
        return FB_BASE + row_offset(row);
    endfunction

    // Row to prefetch: the line after next while visible, otherwise row 0.
    always_comb begin
        sel_row = 10'd0;
        if (next_frame_active && (next_v_pos < 10'(V_LAST_VISIBLE))) begin
            sel_row = next_v_pos + 10'd1;
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge clk40) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch FSM next state, request and buffer write strobe.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        ram_wr_en  = 1'b0;
        case (state)
            IDLE: begin
                if (line_starting) state_next = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (line_starting) begin
                    state_next = mem_ack ? FETCH : ABORT;
                end else if (mem_ack) begin
                    ram_wr_en = 1'b1;
                    if (col == LAST_COL) state_next = DONE;
                end
            end
            ABORT: begin
                mem_req = 1'b1;
                if (mem_ack) state_next = FETCH;
            end
            DONE: begin
                if (line_starting) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    assign underrun_set = line_starting && ((state == FETCH) || (state == ABORT));

    // Column, address, bank swap and bank-valid bookkeeping for the fetch engine.
    always_ff @(posedge clk40) begin
        if (reset) begin
            col         <= 10'd0;
            pending_row <= 10'd0;
            mem_addr    <= 20'd0;
            disp_bank   <= 1'b0;
            bank_valid  <= 2'b00;
        end else begin
            if (line_starting) begin
                disp_bank             <= ~disp_bank;
                bank_valid[disp_bank] <= 1'b0;
                pending_row           <= sel_row;
            end
            case (state)
                IDLE, DONE: begin
                    if (line_starting) begin
                        col      <= 10'd0;
                        mem_addr <= fetch_base(sel_row);
                    end
                end
                FETCH: begin
                    if (line_starting) begin
                        col <= 10'd0;
                        if (mem_ack) mem_addr <= fetch_base(sel_row);
                    end else if (mem_ack) begin
                        col      <= col + 10'd1;
                        mem_addr <= mem_addr + 20'd1;
                        if (col == LAST_COL) bank_valid[~disp_bank] <= 1'b1;
                    end
                end
                ABORT: begin
                    if (mem_ack) begin
                        col      <= 10'd0;
                        mem_addr <= fetch_base(line_starting ? sel_row : pending_row);
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge clk40) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (underrun_set) begin
            underrun <= 1'b1;
        end else if (underrun_clear) begin
            underrun <= 1'b0;
        end
    end

    // Output pipe stage 1: capture timing inputs and the display bank state.
    always_ff @(posedge clk40) begin
        if (reset) begin
            s1_h_pos  <= 10'd0;
            s1_active <= 1'b0;
            s1_hsync  <= 1'b0;
            s1_vsync  <= 1'b0;
            s1_bank   <= 1'b0;
            s1_valid  <= 1'b0;
        end else begin
            s1_h_pos  <= h_pos;
            s1_active <= video_active;
            s1_hsync  <= hsync_in;
            s1_vsync  <= vsync_in;
            s1_bank   <= disp_bank;
            s1_valid  <= bank_valid[disp_bank];
        end
    end

    // Output pipe stage 2: align control bits with the registered RAM read.
    always_ff @(posedge clk40) begin
        if (reset) begin
            s2_active <= 1'b0;
            s2_hsync  <= 1'b0;
            s2_vsync  <= 1'b0;
            s2_valid  <= 1'b0;
        end else begin
            s2_active <= s1_active;
            s2_hsync  <= s1_hsync;
            s2_vsync  <= s1_vsync;
            s2_valid  <= s1_valid;
        end
    end

`ifdef TEST_PATTERN_EN
    // Colour-bar pipe running alongside the line buffer read.
    always_ff @(posedge clk40) begin
        if (reset) begin
            s1_tp_sel <= 1'b0;
            s2_tp_sel <= 1'b0;
            s2_bar    <= BAR_BLACK;
        end else begin
            s1_tp_sel <= test_pattern_sel;
            s2_tp_sel <= s1_tp_sel;
            s2_bar    <= bar_colour(s1_h_pos);
        end
    end
`endif

    // Reads are enabled only in the active region, so the bank being written
    // just after a swap is never read in the same cycle.
    line_buffer_ram #(
        .WORDS  (LINE_WORDS),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk40),
        .wr_en   (ram_wr_en),
        .wr_bank (~disp_bank),
        .wr_addr (col),
        .wr_data (mem_data),
        .rd_en   (s1_active),
        .rd_bank (s1_bank),
        .rd_addr (s1_h_pos),
        .rd_data (ram_q)
    );

    // Final pixel mux: blank outside the active area or when the bank is stale.
    always_comb begin
        pixel_rgb = '0;
        if (s2_active && s2_valid) pixel_rgb = ram_q;
`ifdef TEST_PATTERN_EN
        if (s2_active && s2_tp_sel) pixel_rgb = DATA_W'(s2_bar);
`endif
    end

    assign pixel_active = s2_active;
    assign hsync_out    = s2_hsync;
    assign vsync_out    = s2_vsync;

endmodule

// File: tb/tb_line_fetch_buffer.sv
// Directed bench for line_fetch_buffer: drives one 1056-cycle line at a time,
// logs every output per cycle, then compares selected cycles against
// hand-computed values (memory word = its own address).
module tb_line_fetch_buffer;

    logic        clk40 = 1'b0;
    logic        reset;
    logic        line_starting;
    logic        video_active;
    logic [9:0]  h_pos;
    logic        next_frame_active;
    logic [9:0]  next_v_pos;
    logic        hsync_in;
    logic        vsync_in;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] pixel_rgb;
    logic        pixel_active;
    logic        hsync_out;
    logic        vsync_out;
    logic        underrun;
    logic        underrun_clear;
`ifdef TEST_PATTERN_EN
    logic        test_pattern_sel;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] pix_log    [0:1055];
    logic        active_log [0:1055];
    logic        hs_log     [0:1055];
    logic        vs_log     [0:1055];
    logic        req_log    [0:1055];
    logic        un_log     [0:1055];
    logic [19:0] addr_log   [0:1055];

    int          ack_count;
    logic [19:0] first_ack_addr;
    logic [19:0] last_ack_addr;
    int          hold_viol  = 0;
    logic        slow_ack   = 1'b0;
    logic        ack_phase  = 1'b0;
    logic        prev_req   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic        prev_reset = 1'b1;
    logic [19:0] prev_addr  = 20'd0;

    line_fetch_buffer dut (
        .clk40             (clk40),
        .reset             (reset),
        .line_starting     (line_starting),
        .video_active      (video_active),
        .h_pos             (h_pos),
        .next_frame_active (next_frame_active),
        .next_v_pos        (next_v_pos),
        .hsync_in          (hsync_in),
        .vsync_in          (vsync_in),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .mem_data          (mem_data),
        .pixel_rgb         (pixel_rgb),
        .pixel_active      (pixel_active),
        .hsync_out         (hsync_out),
        .vsync_out         (vsync_out),
        .underrun          (underrun),
        .underrun_clear    (underrun_clear)
`ifdef TEST_PATTERN_EN
        ,
        .test_pattern_sel  (test_pattern_sel)
`endif
    );

    // 40 MHz-style free-running pixel clock.
    always #5 clk40 = ~clk40;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One full line of generator timing plus the memory responder.
    task automatic applyStimulus(input int vpos, input int reset_at, input int clear_at);
        int nv;
        nv = (vpos == 627) ? 0 : vpos + 1;
        ack_count      = 0;
        first_ack_addr = 20'hFFFFF;
        last_ack_addr  = 20'hFFFFF;
        for (int hc = 0; hc < 1056; hc++) begin
            @(negedge clk40);
            pix_log[hc]    = pixel_rgb;
            active_log[hc] = pixel_active;
            hs_log[hc]     = hsync_out;
            vs_log[hc]     = vsync_out;
            req_log[hc]    = mem_req;
            un_log[hc]     = underrun;
            addr_log[hc]   = mem_addr;
            if (prev_req && !prev_ack && !prev_reset && (!mem_req || (mem_addr != prev_addr))) begin
                hold_viol++;
            end
            reset             = (hc == reset_at);
            underrun_clear    = (hc == clear_at);
            line_starting     = (hc == 1055);
            video_active      = (hc < 800) && (vpos < 600);
            h_pos             = (hc < 800) ? 10'(hc) : 10'd0;
            next_v_pos        = 10'(nv);
            next_frame_active = (nv < 600);
            hsync_in          = (hc >= 840) && (hc < 968);
            vsync_in          = (vpos >= 601) && (vpos < 605);
            ack_phase         = ~ack_phase;
            mem_ack           = mem_req && (!slow_ack || ack_phase);
            mem_data          = mem_addr[15:0];
            if (mem_ack) begin
                if (ack_count == 0) first_ack_addr = mem_addr;
                last_ack_addr = mem_addr;
                ack_count++;
            end
            prev_req   = mem_req;
            prev_ack   = mem_ack;
            prev_addr  = mem_addr;
            prev_reset = reset;
        end
    endtask

    initial begin
        reset             = 1'b1;
        line_starting     = 1'b0;
        video_active      = 1'b0;
        h_pos             = 10'd0;
        next_frame_active = 1'b0;
        next_v_pos        = 10'd0;
        hsync_in          = 1'b0;
        vsync_in          = 1'b0;
        mem_ack           = 1'b0;
        mem_data          = 16'd0;
        underrun_clear    = 1'b0;
`ifdef TEST_PATTERN_EN
        test_pattern_sel  = 1'b0;
`endif
        repeat (3) @(negedge clk40);
        checkOutput("rst_mem_req",  32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_pixel",    32'(pixel_rgb), 32'd0);
        checkOutput("rst_active",   32'(pixel_active), 32'd0);
        checkOutput("rst_hsync",    32'(hsync_out), 32'd0);
        checkOutput("rst_vsync",    32'(vsync_out), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);

        // First line after reset only swaps; row 5 is fetched during line 4.
        applyStimulus(3, -1, -1);
        applyStimulus(4, -1, -1);
        checkOutput("l4_stale_pix",   32'(pix_log[102]), 32'd0);
        checkOutput("l4_active",      32'(active_log[102]), 32'd1);
        checkOutput("l4_ack_count",   32'(ack_count), 32'd800);
        checkOutput("l4_first_addr",  32'(first_ack_addr), 32'd4000);
        checkOutput("l4_last_addr",   32'(last_ack_addr), 32'd4799);

        applyStimulus(5, -1, -1);
        checkOutput("l5_pix_h0",      32'(pix_log[2]), 32'd4000);
        checkOutput("l5_pix_h37",     32'(pix_log[39]), 32'd4037);
        checkOutput("l5_pix_h799",    32'(pix_log[801]), 32'd4799);
        checkOutput("l5_pix_blank",   32'(pix_log[802]), 32'd0);
        checkOutput("l5_active_pre",  32'(active_log[1]), 32'd0);
        checkOutput("l5_active_rise", 32'(active_log[2]), 32'd1);
        checkOutput("l5_hs_pre",      32'(hs_log[841]), 32'd0);
        checkOutput("l5_hs_rise",     32'(hs_log[842]), 32'd1);
        checkOutput("l5_hs_last",     32'(hs_log[969]), 32'd1);
        checkOutput("l5_hs_fall",     32'(hs_log[970]), 32'd0);
        checkOutput("l5_underrun",    32'(un_log[500]), 32'd0);

        // Bottom of frame and vertical blank: every fetch is row 0.
        applyStimulus(598, -1, -1);
        applyStimulus(599, -1, -1);
        checkOutput("l599_count",     32'(ack_count), 32'd800);
        checkOutput("l599_first",     32'(first_ack_addr), 32'd0);
        checkOutput("l599_last",      32'(last_ack_addr), 32'd799);
        applyStimulus(600, -1, -1);
        checkOutput("l600_first",     32'(first_ack_addr), 32'd0);
        checkOutput("l600_last",      32'(last_ack_addr), 32'd799);
        applyStimulus(601, -1, -1);
        checkOutput("l601_vs_pre",    32'(vs_log[1]), 32'd0);
        checkOutput("l601_vs_rise",   32'(vs_log[2]), 32'd1);
        checkOutput("l601_inactive",  32'(active_log[100]), 32'd0);
        checkOutput("l601_pix",       32'(pix_log[100]), 32'd0);
        applyStimulus(626, -1, -1);
        applyStimulus(627, -1, -1);
        checkOutput("l627_first",     32'(first_ack_addr), 32'd0);
        checkOutput("l627_last",      32'(last_ack_addr), 32'd799);
        applyStimulus(0, -1, -1);
        checkOutput("l0_pix_h37",     32'(pix_log[39]), 32'd37);
        checkOutput("l0_pix_h799",    32'(pix_log[801]), 32'd799);
        checkOutput("l0_first",       32'(first_ack_addr), 32'd800);

        // Half-rate memory: the row fetched during line 1 cannot finish.
        slow_ack = 1'b1;
        applyStimulus(1, -1, -1);
        checkOutput("l1_pix_h37",     32'(pix_log[39]), 32'd837);
        applyStimulus(2, -1, 100);
        checkOutput("l2_underrun",    32'(un_log[1]), 32'd1);
        checkOutput("l2_req_held",    32'(req_log[0]), 32'd1);
        checkOutput("l2_pix_zero",    32'(pix_log[39]), 32'd0);
        checkOutput("l2_active",      32'(active_log[39]), 32'd1);
        checkOutput("l2_un_before",   32'(un_log[100]), 32'd1);
        checkOutput("l2_un_cleared",  32'(un_log[101]), 32'd0);
        applyStimulus(3, -1, 1055);

        // Full-rate memory again; reset lands mid-fetch.
        slow_ack = 1'b0;
        applyStimulus(10, 401, -1);
        checkOutput("l10_set_wins",   32'(un_log[0]), 32'd1);
        checkOutput("l10_active_pre", 32'(active_log[401]), 32'd1);
        checkOutput("l10_rst_req",    32'(req_log[402]), 32'd0);
        checkOutput("l10_rst_addr",   32'(addr_log[402]), 32'd0);
        checkOutput("l10_rst_active", 32'(active_log[402]), 32'd0);
        checkOutput("l10_rst_pix",    32'(pix_log[402]), 32'd0);
        checkOutput("l10_rst_un",     32'(un_log[402]), 32'd0);
        applyStimulus(11, -1, -1);
        checkOutput("l11_stale_pix",  32'(pix_log[39]), 32'd0);
        checkOutput("l11_active",     32'(active_log[39]), 32'd1);
        applyStimulus(12, -1, -1);
        checkOutput("l12_pix_h37",    32'(pix_log[39]), 32'd9637);

`ifdef TEST_PATTERN_EN
        test_pattern_sel = 1'b1;
        applyStimulus(13, -1, -1);
        checkOutput("tp_h0",          32'(pix_log[2]), 32'h0000FFFF);
        checkOutput("tp_h150",        32'(pix_log[152]), 32'h0000FFE0);
        checkOutput("tp_h250",        32'(pix_log[252]), 32'h000007FF);
        checkOutput("tp_h699",        32'(pix_log[701]), 32'h0000001F);
        checkOutput("tp_h799",        32'(pix_log[801]), 32'h00000000);
        checkOutput("tp_fetch",       32'(ack_count), 32'd800);
        test_pattern_sel = 1'b0;
`endif

        checkOutput("handshake_hold", 32'(hold_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
